// File: rtl/hdmi_mon_pkg.sv
// Shared types, default 1080p60 mode constants and checksum helper for the
// HDMI output timing monitor.
package hdmi_mon_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } mon_state_t;

    localparam int unsigned MODE_H_TOTAL    = 2200;
    localparam int unsigned MODE_HS_WIDTH   = 44;
    localparam int unsigned MODE_ACT_PIXELS = 1920;
    localparam int unsigned MODE_V_TOTAL    = 1125;
    localparam int unsigned MODE_ACT_LINES  = 1080;

    // Sum of the two 18-bit halves of a pixel word, modulo 2^32.
    function automatic logic [31:0] checksum_add(input logic [31:0] acc,
                                                 input logic [35:0] d);
        return acc + {14'd0, d[35:18]} + {14'd0, d[17:0]};
    endfunction

endpackage

// File: rtl/hdmi_pulse_meter.sv
// Saturating interval counter with its own edge detect; latches the count
// when the terminating edge of the watched signal arrives.
module hdmi_pulse_meter #(
    parameter int unsigned W            = 12,
    parameter bit          FREE_RUN     = 1'b0,
    parameter bit          TERM_ON_RISE = 1'b0,
    parameter bit          NEED_PRIME   = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         sig,
    output logic [W-1:0] meas_next,
    output logic [W-1:0] meas
);

    logic         sig_q;
    logic [W-1:0] cnt_q, cnt_d, cnt_run;
    logic [W-1:0] meas_q, meas_d;
    logic         primed_q, primed_d;
    logic         rise, fall, term, cnt_en;

    always_comb begin
        rise     = sig & ~sig_q;
        fall     = ~sig & sig_q;
        term     = TERM_ON_RISE ? rise : fall;
        cnt_en   = FREE_RUN | sig;
        cnt_run  = (cnt_en && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
        cnt_d    = cnt_run;
        primed_d = primed_q;
        meas_d   = meas_q;
        if (clear) begin
            cnt_d    = '0;
            primed_d = 1'b0;
        end else if (term) begin
            // The count includes the terminating cycle when it is a counting cycle.
            cnt_d    = '0;
            primed_d = 1'b1;
            if (!NEED_PRIME || primed_q) begin
                meas_d = cnt_run;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q    <= 1'b0;
            cnt_q    <= '0;
            meas_q   <= '0;
            primed_q <= 1'b0;
        end else begin
            sig_q    <= sig;
            cnt_q    <= cnt_d;
            meas_q   <= meas_d;
            primed_q <= primed_d;
        end
    end

    assign meas_next = meas_d;
    assign meas      = meas_q;

endmodule

// File: rtl/hdmi_timing_monitor.sv
// Passive line/frame timing checker on the ADV7511 pixel bus: measures,
// compares against the expected mode, reports lock, sticky errors and checksum.
module hdmi_timing_monitor
    import hdmi_mon_pkg::*;
#(
    parameter int unsigned H_ADDR         = 12,
    parameter int unsigned V_ADDR         = 12,
    parameter int unsigned EXP_H_TOTAL    = MODE_H_TOTAL,
    parameter int unsigned EXP_HS_WIDTH   = MODE_HS_WIDTH,
    parameter int unsigned EXP_ACT_PIXELS = MODE_ACT_PIXELS,
    parameter int unsigned EXP_V_TOTAL    = MODE_V_TOTAL,
    parameter int unsigned EXP_ACT_LINES  = MODE_ACT_LINES
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [35:0]       vid_d,
    input  logic              vid_de,
    input  logic              vid_hs,
    input  logic              vid_vs,
    input  logic              err_clear,
    output logic [H_ADDR-1:0] meas_h_total,
    output logic [H_ADDR-1:0] meas_hs_width,
    output logic [H_ADDR-1:0] meas_act_pixels,
    output logic [V_ADDR-1:0] meas_v_total,
    output logic [V_ADDR-1:0] meas_act_lines,
    output logic [15:0]       frame_count,
    output logic [31:0]       frame_checksum,
    output logic              status_valid,
    output logic              locked,
    output logic              err_h,
    output logic              err_v,
    output logic              err_act,
    output logic              err_hsw
);

    localparam logic [H_ADDR-1:0] EXP_HT  = H_ADDR'(EXP_H_TOTAL);
    localparam logic [H_ADDR-1:0] EXP_HSW = H_ADDR'(EXP_HS_WIDTH);
    localparam logic [H_ADDR-1:0] EXP_AP  = H_ADDR'(EXP_ACT_PIXELS);
    localparam logic [V_ADDR-1:0] EXP_VT  = V_ADDR'(EXP_V_TOTAL);
    localparam logic [V_ADDR-1:0] EXP_AL  = V_ADDR'(EXP_ACT_LINES);

    mon_state_t        state_q, state_d;
    logic              hs_q, vs_q, de_q;
    logic              hs_rise, vs_rise, de_fall, had_line, meter_clear;
    logic [V_ADDR-1:0] v_cnt_q, v_cnt_d, v_cnt_inc;
    logic [V_ADDR-1:0] act_cnt_q, act_cnt_d, act_cnt_inc, act_latch;
    logic              line_had_de_q, line_had_de_d;
    logic [31:0]       acc_q, acc_d, acc_next;
    logic [V_ADDR-1:0] meas_v_total_q, meas_v_total_d;
    logic [V_ADDR-1:0] meas_act_lines_q, meas_act_lines_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic [31:0]       frame_checksum_q, frame_checksum_d;
    logic              status_valid_q, status_valid_d;
    logic              locked_q, locked_d;
    logic [3:0]        err_q, err_d, mis;
    logic [H_ADDR-1:0] h_total_next, hs_width_next, act_pixels_next;

    hdmi_pulse_meter #(.W(H_ADDR), .FREE_RUN(1'b1), .TERM_ON_RISE(1'b1), .NEED_PRIME(1'b1)) u_h_total (
        .clk(CLK), .rst(RST), .clear(meter_clear), .sig(vid_hs),
        .meas_next(h_total_next), .meas(meas_h_total)
    );

    hdmi_pulse_meter #(.W(H_ADDR), .FREE_RUN(1'b0), .TERM_ON_RISE(1'b0), .NEED_PRIME(1'b0)) u_hs_width (
        .clk(CLK), .rst(RST), .clear(meter_clear), .sig(vid_hs),
        .meas_next(hs_width_next), .meas(meas_hs_width)
    );

    hdmi_pulse_meter #(.W(H_ADDR), .FREE_RUN(1'b0), .TERM_ON_RISE(1'b0), .NEED_PRIME(1'b0)) u_act_pixels (
        .clk(CLK), .rst(RST), .clear(meter_clear), .sig(vid_de),
        .meas_next(act_pixels_next), .meas(meas_act_pixels)
    );

    always_comb begin
        hs_rise     = vid_hs & ~hs_q;
        vs_rise     = vid_vs & ~vs_q;
        de_fall     = ~vid_de & de_q;
        meter_clear = (state_q == HUNT) && !vs_rise;
        had_line    = line_had_de_q | de_fall;
        v_cnt_inc   = (&v_cnt_q) ? v_cnt_q : v_cnt_q + 1'b1;
        act_cnt_inc = (&act_cnt_q) ? act_cnt_q : act_cnt_q + 1'b1;
        // A line ending on the frame-boundary hs_rise still belongs to the old frame.
        act_latch   = (hs_rise && had_line) ? act_cnt_inc : act_cnt_q;
        acc_next    = vid_de ? checksum_add(acc_q, vid_d) : acc_q;
        // err_act covers both active-area dimensions.
        mis = {h_total_next != EXP_HT, v_cnt_q != EXP_VT,
               (act_pixels_next != EXP_AP) || (act_latch != EXP_AL),
               hs_width_next != EXP_HSW};

        v_cnt_d          = v_cnt_q;
        act_cnt_d        = act_cnt_q;
        line_had_de_d    = had_line;
        acc_d            = acc_next;
        meas_v_total_d   = meas_v_total_q;
        meas_act_lines_d = meas_act_lines_q;
        frame_checksum_d = frame_checksum_q;
        frame_count_d    = frame_count_q;
        state_d          = state_q;
        status_valid_d   = status_valid_q;
        locked_d         = locked_q;
        err_d            = err_clear ? '0 : err_q;

        if (hs_rise) begin
            v_cnt_d       = v_cnt_inc;
            line_had_de_d = 1'b0;
            if (had_line) begin
                act_cnt_d = act_cnt_inc;
            end
        end

        if (vs_rise) begin
            v_cnt_d       = hs_rise ? V_ADDR'(1) : '0;
            act_cnt_d     = '0;
            acc_d         = '0;
            line_had_de_d = 1'b0;
            frame_count_d = frame_count_q + 1'b1;
            if (state_q != HUNT) begin
                meas_v_total_d   = v_cnt_q;
                meas_act_lines_d = act_latch;
                frame_checksum_d = acc_next;
            end
        end else if (state_q == HUNT) begin
            v_cnt_d       = '0;
            act_cnt_d     = '0;
            acc_d         = '0;
            line_had_de_d = 1'b0;
        end

        case (state_q)
            HUNT: begin
                if (vs_rise) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (vs_rise) begin
                    status_valid_d = 1'b1;
                    if (mis == '0) begin
                        locked_d = 1'b1;
                        state_d  = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (vs_rise && (mis != '0)) begin
                    err_d    = err_d | mis;
                    locked_d = 1'b0;
                    state_d  = MEASURE;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q          <= HUNT;
            hs_q             <= 1'b0;
            vs_q             <= 1'b0;
            de_q             <= 1'b0;
            v_cnt_q          <= '0;
            act_cnt_q        <= '0;
            line_had_de_q    <= 1'b0;
            acc_q            <= '0;
            meas_v_total_q   <= '0;
            meas_act_lines_q <= '0;
            frame_count_q    <= '0;
            frame_checksum_q <= '0;
            status_valid_q   <= 1'b0;
            locked_q         <= 1'b0;
            err_q            <= '0;
        end else begin
            state_q          <= state_d;
            hs_q             <= vid_hs;
            vs_q             <= vid_vs;
            de_q             <= vid_de;
            v_cnt_q          <= v_cnt_d;
            act_cnt_q        <= act_cnt_d;
            line_had_de_q    <= line_had_de_d;
            acc_q            <= acc_d;
            meas_v_total_q   <= meas_v_total_d;
            meas_act_lines_q <= meas_act_lines_d;
            frame_count_q    <= frame_count_d;
            frame_checksum_q <= frame_checksum_d;
            status_valid_q   <= status_valid_d;
            locked_q         <= locked_d;
            err_q            <= err_d;
        end
    end

    assign meas_v_total   = meas_v_total_q;
    assign meas_act_lines = meas_act_lines_q;
    assign frame_count    = frame_count_q;
    assign frame_checksum = frame_checksum_q;
    assign status_valid   = status_valid_q;
    assign locked         = locked_q;
    assign {err_h, err_v, err_act, err_hsw} = err_q;

endmodule
